// File: rtl/imm_gen_pipe_if.sv
`timescale 1ns/1ps
// Handshake bundle for imm_gen_pipe: request side (in_*) and result side (out_*).
// The master drives requests and consumes results; the slave is the generator.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [24:0]      in_instr;
  logic [2:0]       in_sel_ext;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_instr, in_sel_ext, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal, count
  );

  modport slave (
    input  in_valid, in_instr, in_sel_ext, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal, count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
// Decode-stage immediate generator: extracts and extends the immediate combinationally,
// then queues immediate, tag and illegal flag in a DEPTH-entry in-order buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           reset,
  input logic           flush,
  imm_gen_pipe_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  generate
    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("imm_gen_pipe: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [31:7]      instr;
  logic [XLEN-1:0]  imm_next;
  logic             ill_next;

  logic [XLEN-1:0]  mem_imm [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [DEPTH-1:0] mem_ill;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  assign instr = bus.in_instr;

  // Size casts of signed operands sign-extend, which also covers U with XLEN=32 (no-op).
  always_comb begin
    imm_next = '0;
    ill_next = 1'b0;
    case (bus.in_sel_ext)
      3'b000: imm_next = XLEN'($signed(instr[31:20]));
      3'b001: imm_next = XLEN'($signed({instr[31:25], instr[11:7]}));
      3'b010: imm_next = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      3'b011: imm_next = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      3'b100: imm_next = XLEN'($signed({instr[31:12], 12'b0}));
      3'b101: imm_next = XLEN'(instr[19:15]);
      3'b110: begin
        if (XLEN == 64) begin
          imm_next = XLEN'(instr[25:20]);
        end else begin
          imm_next = XLEN'(instr[24:20]);
          ill_next = instr[25];
        end
      end
      default: ill_next = 1'b1;
    endcase
  end

  // in_ready looks only at the registered count, so a full buffer never accepts
  // even when the head is leaving in the same cycle.
  assign bus.in_ready    = (cnt != CW'(DEPTH)) & ~reset;
  assign bus.out_valid   = (cnt != '0);
  assign push            = bus.in_valid & bus.in_ready;
  assign pop             = bus.out_valid & bus.out_ready;
  assign bus.out_imm     = mem_imm[rd_ptr];
  assign bus.out_tag     = mem_tag[rd_ptr];
  assign bus.out_illegal = mem_ill[rd_ptr];
  assign bus.count       = cnt;

  // Storage is cleared on reset so the head outputs read as zero rather than X.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      mem_ill <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm[i] <= '0;
        mem_tag[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= imm_next;
        mem_tag[wr_ptr] <= bus.in_tag;
        mem_ill[wr_ptr] <= ill_next;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
`timescale 1ns/1ps
// Bench for imm_gen_pipe: instance A is XLEN=32/DEPTH=2, instance B is XLEN=64/DEPTH=4.
// Accepted requests are modelled into per-instance queues and checked as results are consumed.
module tb_imm_gen_pipe;
  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic clk;
  logic reset;
  logic flush;

  int tests;
  int fails;
  exp_t exp_a[$];
  exp_t exp_b[$];

  imm_gen_pipe_if #(.XLEN(32), .DEPTH(2), .TAG_W(5)) if_a ();
  imm_gen_pipe_if #(.XLEN(64), .DEPTH(4), .TAG_W(5)) if_b ();

  imm_gen_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(5)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .bus(if_a)
  );
  imm_gen_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(5)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .bus(if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extraction written directly from the RISC-V field layouts.
  function automatic exp_t model(input int xlen, input logic [24:0] ins25,
                                 input logic [2:0] sel, input logic [4:0] tag);
    logic [31:0] i;
    exp_t e;
    i = {ins25, 7'b0};
    e.tag = tag;
    e.ill = 1'b0;
    case (sel)
      3'd0: e.imm = {{52{i[31]}}, i[31:20]};
      3'd1: e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: e.imm = {{32{i[31]}}, i[31:12], 12'h000};
      3'd5: e.imm = {59'b0, i[19:15]};
      3'd6: begin
        if (xlen == 64) begin
          e.imm = {58'b0, i[25:20]};
        end else begin
          e.imm = {59'b0, i[24:20]};
          e.ill = i[25];
        end
      end
      default: begin
        e.imm = 64'h0;
        e.ill = 1'b1;
      end
    endcase
    if (xlen == 32) e.imm[63:32] = 32'h0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  // Scoreboard for instance A: pops compared first, then the new push appended.
  always @(negedge clk) begin
    exp_t e;
    if (reset || flush) begin
      exp_a.delete();
    end else begin
      if (if_a.out_valid && if_a.out_ready) begin
        if (exp_a.size() == 0) begin
          checkOutput("A_unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_a.pop_front();
          checkOutput("A_sb_imm", {32'h0, if_a.out_imm}, e.imm);
          checkOutput("A_sb_tag", 64'(if_a.out_tag), 64'(e.tag));
          checkOutput("A_sb_ill", 64'(if_a.out_illegal), 64'(e.ill));
        end
      end
      if (if_a.in_valid && if_a.in_ready)
        exp_a.push_back(model(32, if_a.in_instr, if_a.in_sel_ext, if_a.in_tag));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset || flush) begin
      exp_b.delete();
    end else begin
      if (if_b.out_valid && if_b.out_ready) begin
        if (exp_b.size() == 0) begin
          checkOutput("B_unexpected_output", 64'd1, 64'd0);
        end else begin
          e = exp_b.pop_front();
          checkOutput("B_sb_imm", if_b.out_imm, e.imm);
          checkOutput("B_sb_tag", 64'(if_b.out_tag), 64'(e.tag));
          checkOutput("B_sb_ill", 64'(if_b.out_illegal), 64'(e.ill));
        end
      end
      if (if_b.in_valid && if_b.in_ready)
        exp_b.push_back(model(64, if_b.in_instr, if_b.in_sel_ext, if_b.in_tag));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input bit to_b, input logic [31:0] ins,
                               input logic [2:0] sel, input logic [4:0] tag);
    if (to_b) begin
      if_b.in_valid = 1'b1; if_b.in_instr = ins[31:7]; if_b.in_sel_ext = sel; if_b.in_tag = tag;
    end else begin
      if_a.in_valid = 1'b1; if_a.in_instr = ins[31:7]; if_a.in_sel_ext = sel; if_a.in_tag = tag;
    end
  endtask

  task automatic setOutReady(input bit to_b, input logic v);
    if (to_b) if_b.out_ready = v;
    else if_a.out_ready = v;
  endtask

  // Push one request into an empty buffer, confirm there is no same-cycle bypass,
  // inspect the head against a hand-computed constant, then consume it.
  task automatic pushAndPeek(input bit to_b, input logic [31:0] ins, input logic [2:0] sel,
                             input logic [4:0] tag, input logic [63:0] exp_imm,
                             input logic exp_ill, input string name);
    applyStimulus(to_b, ins, sel, tag);
    @(negedge clk);
    checkOutput({name, "_nobypass"}, to_b ? 64'(if_b.out_valid) : 64'(if_a.out_valid), 64'd0);
    @(posedge clk); #1;
    if_a.in_valid = 1'b0;
    if_b.in_valid = 1'b0;
    @(negedge clk);
    checkOutput({name, "_valid"}, to_b ? 64'(if_b.out_valid) : 64'(if_a.out_valid), 64'd1);
    checkOutput({name, "_imm"}, to_b ? if_b.out_imm : {32'h0, if_a.out_imm}, exp_imm);
    checkOutput({name, "_tag"}, to_b ? 64'(if_b.out_tag) : 64'(if_a.out_tag), 64'(tag));
    checkOutput({name, "_ill"}, to_b ? 64'(if_b.out_illegal) : 64'(if_a.out_illegal), 64'(exp_ill));
    setOutReady(to_b, 1'b1);
    @(posedge clk); #1;
    setOutReady(to_b, 1'b0);
  endtask

  initial begin
    int max_cnt;
    int guard;
    bit stable;
    bit pushed;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    flush = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_instr = '0; if_a.in_sel_ext = '0; if_a.in_tag = '0; if_a.out_ready = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_instr = '0; if_b.in_sel_ext = '0; if_b.in_tag = '0; if_b.out_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(if_a.in_ready), 64'd0);
    checkOutput("rst_count", 64'(if_a.count), 64'd0);
    checkOutput("rst_out_valid", 64'(if_a.out_valid), 64'd0);
    checkOutput("rst_out_imm", {32'h0, if_a.out_imm}, 64'd0);
    checkOutput("rst_out_tag", 64'(if_a.out_tag), 64'd0);
    checkOutput("rst_out_ill", 64'(if_a.out_illegal), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_ready", 64'(if_a.in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed formats with hand-computed results
    pushAndPeek(0, 32'hFFF00093, 3'd0, 5'd1, 64'hFFFF_FFFF, 1'b0, "A_I");
    pushAndPeek(0, 32'hFE000EE3, 3'd2, 5'd2, 64'hFFFF_FFFC, 1'b0, "A_B");
    pushAndPeek(0, 32'h800000B7, 3'd4, 5'd3, 64'h8000_0000, 1'b0, "A_U");
    pushAndPeek(1, 32'h800000B7, 3'd4, 5'd4, 64'hFFFF_FFFF_8000_0000, 1'b0, "B_U");
    pushAndPeek(1, 32'h03F00013, 3'd6, 5'd5, 64'h3F, 1'b0, "B_shamt");
    pushAndPeek(0, 32'h03F00013, 3'd6, 5'd6, 64'h1F, 1'b1, "A_shamt");
    pushAndPeek(0, 32'h000F8073, 3'd5, 5'd7, 64'h1F, 1'b0, "A_zimm");
    pushAndPeek(0, 32'hFFFFFFFF, 3'd7, 5'd8, 64'h0, 1'b1, "A_sel7");
    pushAndPeek(1, 32'hFE112E23, 3'd1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, "B_S");
    pushAndPeek(1, 32'h0080006F, 3'd3, 5'd10, 64'h8, 1'b0, "B_J");

    // Backpressure on the two-entry buffer
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, $urandom, 3'($urandom_range(0, 7)), 5'(k + 1));
      @(posedge clk); #1;
    end
    applyStimulus(0, $urandom, 3'($urandom_range(0, 7)), 5'd3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("A_bp_ready", 64'(if_a.in_ready), 64'd0);
      checkOutput("A_bp_count", 64'(if_a.count), 64'd2);
      checkOutput("A_bp_head", 64'(if_a.out_tag), 64'd1);
      @(posedge clk); #1;
    end
    if_a.out_ready = 1'b1;
    max_cnt = 0;
    pushed = 1'b0;
    guard = 0;
    while (guard < 12 && !(pushed && !if_a.out_valid)) begin
      @(negedge clk);
      if (int'(if_a.count) > max_cnt) max_cnt = int'(if_a.count);
      if (if_a.in_valid && if_a.in_ready) pushed = 1'b1;
      @(posedge clk); #1;
      if (pushed) if_a.in_valid = 1'b0;
      guard++;
    end
    if_a.out_ready = 1'b0;
    checkOutput("A_bp_done_in_time", 64'(pushed && !if_a.out_valid), 64'd1);
    checkOutput("A_bp_max_count", 64'(max_cnt), 64'd2);
    checkOutput("A_bp_sb_empty", 64'(exp_a.size()), 64'd0);

    // Steady stream on the four-entry buffer with two entries resident
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, $urandom, 3'($urandom_range(0, 7)), 5'(16 + k));
      @(posedge clk); #1;
    end
    if_b.out_ready = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, $urandom, 3'($urandom_range(0, 7)), 5'(18 + k));
      @(negedge clk);
      if (if_b.count != 3'd2 || !if_b.out_valid || !if_b.in_ready) stable = 1'b0;
      @(posedge clk); #1;
    end
    if_b.in_valid = 1'b0;
    checkOutput("B_stream_steady", 64'(stable), 64'd1);
    guard = 0;
    while (if_b.out_valid && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    if_b.out_ready = 1'b0;
    checkOutput("B_stream_drained", 64'(if_b.out_valid), 64'd0);
    checkOutput("B_stream_sb_empty", 64'(exp_b.size()), 64'd0);

    // Flush with a simultaneous push and pop
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, $urandom, 3'($urandom_range(0, 7)), 5'(k + 1));
      @(posedge clk); #1;
    end
    if_b.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("B_fl_pre_count", 64'(if_b.count), 64'd3);
    @(posedge clk); #1;
    applyStimulus(1, 32'h12345678, 3'd0, 5'd9);
    if_b.out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if_b.in_valid = 1'b0;
    if_b.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("B_fl_count", 64'(if_b.count), 64'd0);
    checkOutput("B_fl_valid", 64'(if_b.out_valid), 64'd0);
    @(posedge clk); #1;
    pushAndPeek(1, 32'h00A00093, 3'd0, 5'd26, 64'hA, 1'b0, "B_postflush");

    // Reset held two cycles while both buffers hold data
    applyStimulus(0, 32'hFFF00093, 3'd0, 5'd7);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, $urandom, 3'($urandom_range(0, 7)), 5'(k + 20));
      @(posedge clk); #1;
      if_a.in_valid = 1'b0;
    end
    if_b.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("A_prerst_count", 64'(if_a.count), 64'd1);
    checkOutput("B_prerst_count", 64'(if_b.count), 64'd3);
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(1, 32'h00100093, 3'd0, 5'd31);
    @(negedge clk);
    checkOutput("B_rst_ready_now", 64'(if_b.in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("A_rst2_ready", 64'(if_a.in_ready), 64'd0);
    checkOutput("B_rst2_ready", 64'(if_b.in_ready), 64'd0);
    checkOutput("A_rst2_count", 64'(if_a.count), 64'd0);
    checkOutput("B_rst2_count", 64'(if_b.count), 64'd0);
    checkOutput("B_rst2_valid", 64'(if_b.out_valid), 64'd0);
    checkOutput("A_rst2_imm", {32'h0, if_a.out_imm}, 64'd0);
    checkOutput("B_rst2_imm", if_b.out_imm, 64'd0);
    checkOutput("B_rst2_tag", 64'(if_b.out_tag), 64'd0);
    checkOutput("B_rst2_ill", 64'(if_b.out_illegal), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    if_b.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("A_rst_release_ready", 64'(if_a.in_ready), 64'd1);
    checkOutput("B_rst_release_ready", 64'(if_b.in_ready), 64'd1);
    checkOutput("B_rst_release_valid", 64'(if_b.out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, buffered immediate generator for the decode stage of the pipelined core. It accepts instruction bits [31:7], a format select and a tag over a valid/ready handshake. It extracts the immediate, extends it to XLEN, and queues the result in a DEPTH-entry in-order buffer. It supports RV32/RV64 and adds CSR-zimm and shift-amount formats, with illegal-encoding flagging.

Parameters:
XLEN, 32, datapath width; only 32 or 64 are legal, any other value is an elaboration error.
DEPTH, 2, buffer entries; power of two, at least 2.
TAG_W, 5, width of the sideband tag (rd or ROB index) carried alongside each result.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
flush  input  1  synchronous buffer clear (pipeline redirect)
in_valid  input  1  request valid
in_ready  output  1  buffer can accept (not full)
in_instr  input  25  instruction bits [31:7]
in_sel_ext  input  3  immediate format select
in_tag  input  TAG_W  sideband tag
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head
out_imm  output  XLEN  extended immediate
out_tag  output  TAG_W  tag of head entry
out_illegal  output  1  head entry had an illegal select or a reserved encoding
count  output  clog2(DEPTH)+1  occupancy

Behaviour:
- Formats, selected by in_sel_ext. All sign extension is from instr[31] up to XLEN.
  - 000 I: instr[31:20].
  - 001 S: {instr[31:25], instr[11:7]}.
  - 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 100 U: {instr[31:12], 12'b0}; sign-extended to XLEN when XLEN=64.
  - 101 CSR zimm: zero-extended instr[19:15].
  - 110 shamt: zero-extended instr[25:20] when XLEN=64; instr[24:20] when XLEN=32. With XLEN=32 and instr[25]=1, illegal=1.
  - 111: imm=0, illegal=1.
- Extraction is combinational at the input. The result, tag and illegal bit are written into the buffer on push.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & ~reset. It is derived from registered count and does not look ahead to a same-cycle pop. When full with a pop in progress, no push occurs.
- Latency: an accepted request appears on out_* one cycle later at the earliest. There is no input-to-output bypass, including when the buffer is empty.
- Ordering: strict FIFO. out_* reflect the head entry and stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop (count not 0, not DEPTH): count is unchanged; both pointers advance.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count increments on push only, decrements on pop only.
- Empty: out_valid=0. out_imm, out_tag and out_illegal are don't-care, but must not be X in simulation; drive stored data.
- flush: next cycle count=0, pointers=0, out_valid=0. flush overrides a same-cycle push and pop, and the pushed data is discarded.
- Reset values: count=0, pointers=0, out_valid=0, in_ready=0 during reset, out_imm=0, out_tag=0, out_illegal=0.
- Reset asserted mid-operation discards all entries exactly as flush does; in_ready rises the first cycle after reset deasserts.
- in_instr, in_sel_ext and in_tag are sampled only on push. in_valid may drop without a push (no stickiness required).

Test Plan:
- XLEN=32: push instr 0xFFF00093, sel=000, tag=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag=1, out_illegal=0.
- XLEN=32: push 0xFE000EE3 sel=010 -> out_imm=0xFFFFFFFC. Push 0x800000B7 sel=100 -> 0x80000000. With XLEN=64, the same U push -> 0xFFFFFFFF80000000.
- Shift and zimm: XLEN=64, instr[25:20]=111111, sel=110 -> 0x3F, illegal=0. XLEN=32, same instr -> 0x1F, illegal=1. sel=101 with instr[19:15]=11111 -> 0x1F. sel=111 -> imm=0, illegal=1.
- Backpressure: DEPTH=2, out_ready=0, offer 3 requests with tags 1,2,3 -> in_ready=0 after two pushes, count=2, head stable at tag 1. Raise out_ready -> tags emerge 1,2,3 in order, count never exceeds 2.
- Steady stream, DEPTH=4: in_valid=out_ready=1 for 20 cycles with incrementing tags -> one result per cycle, count constant, wrap-around seen with no loss or duplication.
- Flush/reset: count=3, assert flush together with a push -> next cycle count=0, out_valid=0, pushed entry absent. Repeat with reset held 2 cycles -> in_ready=0 during reset, all outputs at reset values.
